// File: rtl/row_flip_pkg.sv
// rtl/row_flip_pkg.sv - mode encodings shared by the row_flip engine
package row_flip_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_BREV   = 2'b01,
    MODE_MIRROR = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Mode 11 behaves as pass-through, so only the two named modes reverse bits
  function automatic logic mode_reverses(input logic [1:0] m);
    return (m == MODE_BREV) || (m == MODE_MIRROR);
  endfunction

endpackage

// File: rtl/row_flip_bit_rev.sv
// rtl/row_flip_bit_rev.sv - combinational in-word bit reversal, optional preserved MSB
module bit_rev #(
  parameter int WORD_W   = 8,
  parameter bit KEEP_MSB = 1'b1
) (
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_data
);

  localparam int RW = KEEP_MSB ? WORD_W - 1 : WORD_W;

  for (genvar g = 0; g < RW; g++) begin : g_rev
    assign o_data[g] = i_data[RW-1-g];
  end

  if (KEEP_MSB) begin : g_keep
    assign o_data[WORD_W-1] = i_data[WORD_W-1];
  end

endmodule

// File: rtl/row_flip.sv
// rtl/row_flip.sv - ping-pong row buffer re-emitting rows as pass, bit-reversed or mirrored
module row_flip
  import row_flip_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int ROW_WORDS = 4,
  parameter bit KEEP_MSB  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              err_len
);

  localparam int              IW       = $clog2(ROW_WORDS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(ROW_WORDS - 1);

  logic [WORD_W-1:0] r_mem [2][ROW_WORDS];
  logic [1:0]        r_mode [2];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [IW-1:0]     r_k;
  logic [IW-1:0]     r_j;
  logic              r_out_valid;
  logic              r_out_last;
  logic [WORD_W-1:0] r_out_data;
  logic              r_err;

  logic              w_wr_acc;
  logic              w_commit;
  logic              w_load;
  logic              w_drain_done;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;
  logic [1:0]        w_rd_mode;
  logic [IW-1:0]     w_src;
  logic [WORD_W-1:0] w_raw;
  logic [WORD_W-1:0] w_rev;
  logic [WORD_W-1:0] w_xform;

  assign in_ready     = !r_full[r_wr_bank];
  assign w_wr_acc     = in_valid && in_ready;
  assign w_commit     = w_wr_acc && (in_last || (r_k == LAST_IDX));
  // The output register refills from the bank whenever it is empty or being handed off
  assign w_load       = r_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_drain_done = w_load && (r_j == LAST_IDX);

  assign w_full_set = {w_commit && r_wr_bank, w_commit && !r_wr_bank};
  assign w_full_clr = {w_drain_done && r_rd_bank, w_drain_done && !r_rd_bank};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_k       <= '0;
      r_err     <= 1'b0;
      r_mode[0] <= MODE_PASS;
      r_mode[1] <= MODE_PASS;
    end else begin
      r_err <= w_wr_acc && (in_last != (r_k == LAST_IDX));
      if (w_wr_acc) begin
        if (r_k == '0) r_mode[r_wr_bank] <= mode;
        if (w_commit) begin
          r_k       <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  // First word of a row blanks the bank so a short row reads back zeros
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      if (r_k == '0) begin
        for (int i = 0; i < ROW_WORDS; i++) r_mem[r_wr_bank][i] <= '0;
      end
      r_mem[r_wr_bank][r_k] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_full <= 2'b00;
    else        r_full <= (r_full | w_full_set) & ~w_full_clr;
  end

  assign w_rd_mode = r_mode[r_rd_bank];
  assign w_src     = (w_rd_mode == MODE_MIRROR) ? (LAST_IDX - r_j) : r_j;
  assign w_raw     = r_mem[r_rd_bank][w_src];
  assign w_xform   = mode_reverses(w_rd_mode) ? w_rev : w_raw;

  bit_rev #(
    .WORD_W   (WORD_W),
    .KEEP_MSB (KEEP_MSB)
  ) u_bit_rev (
    .i_data (w_raw),
    .o_data (w_rev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank   <= 1'b0;
      r_j         <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_xform;
      r_out_last  <= (r_j == LAST_IDX);
      if (w_drain_done) begin
        r_j       <= '0;
        r_rd_bank <= !r_rd_bank;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign err_len   = r_err;

endmodule
